// File: rtl/switch_debounce.sv
// Two-flop synchronized switch debouncer feeding the CPU io_rdata read path.
// Define SW_DEBOUNCE_EN to build the settle timer; without it io_rdata simply re-registers sync2.
module switch_debounce #(
  parameter int unsigned           WIDTH           = 24,
  parameter int unsigned           DEBOUNCE_CYCLES = 20000,
  parameter logic [WIDTH-1:0]      RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             fpga_rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] io_rdata,
  output logic             sw_changed,
  output logic             settling
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] io_q, io_d;
  logic             changed_q, changed_d;

  // sw_raw is only ever consumed by the first synchronizer stage.
  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (fpga_rst) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef SW_DEBOUNCE_EN

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             settling_q, settling_d;

  // The whole candidate word commits at once, so io_rdata never mixes old and new bits.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    io_d      = io_q;
    changed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != io_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = SETTLING;
        end
      end
      SETTLING: begin
        if (sync2_q == io_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          io_d      = cand_q;
          changed_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    settling_d = (state_d == SETTLING);
  end

  always_ff @(posedge clk) begin
    if (fpga_rst) begin
      state_q    <= IDLE;
      cand_q     <= RESET_VALUE;
      cnt_q      <= '0;
      io_q       <= RESET_VALUE;
      changed_q  <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      io_q       <= io_d;
      changed_q  <= changed_d;
      settling_q <= settling_d;
    end
  end

  assign settling = settling_q;

`else

  // Undebounced build: register the synchronized level and flag any word change.
  always_comb begin
    io_d      = sync2_q;
    changed_d = (sync2_q != io_q);
  end

  always_ff @(posedge clk) begin
    if (fpga_rst) begin
      io_q      <= RESET_VALUE;
      changed_q <= 1'b0;
    end else begin
      io_q      <= io_d;
      changed_q <= changed_d;
    end
  end

  assign settling = 1'b0;

`endif

  assign io_rdata   = io_q;
  assign sw_changed = changed_q;

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 24, giving the switch vector width, matched to the CPU io_rdata bus.
REQ-002 The block SHALL have a parameter DEBOUNCE_CYCLES, default 20000, giving the number of clk cycles an input must hold steady before commit; legal minimum is 2.
REQ-003 The block SHALL have a parameter RESET_VALUE, default all zeros, WIDTH bits, giving the io_rdata value after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port fpga_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port sw_raw, input, WIDTH bits: asynchronous board switch levels.
REQ-007 The block SHALL have port io_rdata, output, WIDTH bits: the debounced switch word consumed by the CPU I/O read path.
REQ-008 The block SHALL have port sw_changed, output, 1 bit: a one-cycle pulse when io_rdata takes a new value.
REQ-009 The block SHALL have port settling, output, 1 bit: high while a candidate value is being timed.

Function
REQ-010 sw_raw SHALL pass through a two-stage synchronizer (sync1, then sync2) before any comparison; no logic SHALL use sw_raw directly.
REQ-011 The FSM SHALL have exactly two states, IDLE and SETTLING, plus a WIDTH-bit candidate register and a counter of $clog2(DEBOUNCE_CYCLES) bits.
REQ-012 In IDLE with sync2 != io_rdata, the block SHALL load candidate with sync2, clear the counter, and enter SETTLING.
REQ-013 In IDLE with sync2 == io_rdata, the block SHALL hold all state.
REQ-014 In SETTLING with sync2 == candidate and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 In SETTLING with sync2 == candidate and counter == DEBOUNCE_CYCLES-1, the block SHALL load io_rdata with candidate, pulse sw_changed for one cycle, and return to IDLE.
REQ-016 In SETTLING with sync2 != candidate and sync2 != io_rdata, the block SHALL load candidate with sync2, clear the counter, and stay in SETTLING (restart on a new value).
REQ-017 In SETTLING with sync2 == io_rdata, the block SHALL return to IDLE and clear the counter, with no sw_changed pulse (a glitch is rejected).
REQ-018 For a clean step on sw_raw before edge 1, io_rdata SHALL update at edge DEBOUNCE_CYCLES+3, with sw_changed high for the cycle after that edge.
REQ-019 Multi-bit changes SHALL commit atomically as one word; io_rdata SHALL never show a partial mix of old and new bits.
REQ-020 settling SHALL equal (state == SETTLING), registered.
REQ-021 The counter SHALL never wrap; it saturates by construction at DEBOUNCE_CYCLES-1.

Reset
REQ-022 While fpga_rst is high at a clock edge, the block SHALL set sync1, sync2, candidate and io_rdata to RESET_VALUE, clear the counter, set sw_changed=0 and settling=0, and set state to IDLE.
REQ-023 A reset asserted mid-SETTLING SHALL discard the pending candidate without any sw_changed pulse.
REQ-024 After reset release, a sw_raw value differing from RESET_VALUE SHALL be debounced per REQ-012 to REQ-018.

Configuration
REQ-025 Macro SW_DEBOUNCE_EN, when defined, SHALL compile in the SETTLING timer behaviour of REQ-011 to REQ-021.
REQ-026 When SW_DEBOUNCE_EN is undefined, io_rdata SHALL register sync2 every cycle (step on sw_raw appears at edge 3), sw_changed SHALL pulse whenever the registered value changes, settling SHALL be tied 0, and the counter and candidate SHALL not be built.

Verification
REQ-027 Bench SHALL use WIDTH=24, DEBOUNCE_CYCLES=4, RESET_VALUE=0, and SW_DEBOUNCE_EN defined unless stated.
REQ-028 Scenario, clean step: reset, then sw_raw=24'h800107 held -> io_rdata=24'h800107 at edge 7 after the change, one sw_changed pulse, settling high for edges 3..6.
REQ-029 Scenario, glitch: from io_rdata=0, sw_raw=24'h7F0000 for 2 cycles then back to 0 -> io_rdata stays 0, no sw_changed, settling returns low.
REQ-030 Scenario, restart: sw_raw=24'h010040, then after 2 cycles 24'h320080 held -> candidate restarts, io_rdata=24'h320080 committed directly (never 24'h010040), one pulse.
REQ-031 Scenario, reset mid-settle: sw_raw=24'h880300 and assert fpga_rst at the 2nd SETTLING cycle -> all outputs return to reset values, no pulse; after release, commit at edge 7.
REQ-032 Scenario, macro off: build without SW_DEBOUNCE_EN, step sw_raw to 24'h930705 -> io_rdata updates at edge 3, one sw_changed pulse, settling constant 0.
